// File: rtl/sumador_pkg.sv
// Shared types and defaults for the sumador sequencing controller.
package sumador_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sumador_seq_ctrl_strb_edge.sv
// Rising-edge detector for the load strobe; the history register runs even when disabled,
// so a strobe still high on re-enable does not look like a fresh edge.
module strb_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic en,
  output logic rise
);

  logic strb_q_r;

  // Strobe history, sampled every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q_r <= 1'b0;
    end else begin
      strb_q_r <= d;
    end
  end

  assign rise = d & ~strb_q_r & en;

endmodule

// File: rtl/sumador_seq_ctrl.sv
// Operand sequencer for the external 8-bit adder: loads A then B from a shared bus,
// executes for one cycle and registers sum/carry, with optional carry chaining.
module sumador_seq_ctrl
  import sumador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_strb,
  input  logic             chain,
  input  logic             clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  seq_state_t       state_r, next_state_s;
  logic             rise_s;
  logic             ld_a_s, ld_b_s, exec_s, err_set_s;
  logic [WIDTH-1:0] op_a_r, op_b_r, sum_r;
  logic             cin_q_r, carry_r, done_r, err_r;

  strb_edge u_strb_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ld_strb),
    .en   (ena),
    .rise (rise_s)
  );

  // Next-state and load-enable decode
  always_comb begin
    next_state_s = state_r;
    ld_a_s       = 1'b0;
    ld_b_s       = 1'b0;
    exec_s       = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      S_A: begin
        if (rise_s) begin
          ld_a_s       = 1'b1;
          next_state_s = S_B;
        end else begin
          next_state_s = S_A;
        end
      end
      S_B: begin
        if (rise_s) begin
          ld_b_s       = 1'b1;
          next_state_s = S_EXEC;
        end else begin
          next_state_s = S_B;
        end
      end
      S_EXEC: begin
        // An edge arriving here is dropped; the execute still completes.
        exec_s       = ena;
        err_set_s    = rise_s;
        next_state_s = ena ? S_A : S_EXEC;
      end
      default: next_state_s = S_A;
    endcase
  end

  // State, operand and result registers; clr outranks everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_A;
      op_a_r  <= {WIDTH{1'b0}};
      op_b_r  <= {WIDTH{1'b0}};
      cin_q_r <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (clr) begin
      state_r <= S_A;
      cin_q_r <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (ld_a_s) begin
        op_a_r  <= data_in;
        cin_q_r <= chain ? carry_r : 1'b0;
      end
      if (ld_b_s) begin
        op_b_r <= data_in;
      end
      if (exec_s) begin
        sum_r   <= add_sum;
        carry_r <= add_cout;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end
      done_r <= exec_s;
    end
  end

  assign add_a     = op_a_r;
  assign add_b     = op_b_r;
  assign add_cin   = cin_q_r;
  assign sum_out   = sum_r;
  assign carry_out = carry_r;
  assign done      = done_r;
  assign err       = err_r;
  assign busy      = (state_r != S_A);
  assign state_dbg = state_r;

endmodule

// File: tb/tb_sumador_seq_ctrl.sv
// Scoreboard bench for sumador_seq_ctrl: directed scenarios plus random chained additions.
module tb_sumador_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       ld_strb = 1'b0;
  logic       chain = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] add_a, add_b, add_sum, sum_out;
  logic       add_cin, add_cout, carry_out, busy, done, err;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int model_carry = 0;

  always #5 clk = ~clk;

  // External adder the controller drives
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  sumador_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .ld_strb(ld_strb),
    .chain(chain), .clr(clr), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .sum_out(sum_out), .carry_out(carry_out),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input logic ch);
    @(negedge clk);
    data_in = d;
    chain   = ch;
    ld_strb = 1'b1;
    @(negedge clk);
    ld_strb = 1'b0;
  endtask

  // Reference: full-width integer addition, carry kept between chained operations
  function automatic int ref_add(input int a, input int b, input bit ch);
    int r;
    r = a + b + (ch ? model_carry : 0);
    model_carry = r / 256;
    return r;
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ch, input int gap);
    exp_q.push_back(ref_add(int'(a), int'(b), ch));
    strobe(a, ch);
    repeat (gap) @(negedge clk);
    strobe(b, 1'b0);
  endtask

  // Monitor: every done pulse must match the oldest expected result
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'({carry_out, sum_out}), 32'(e));
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add and done timing
    do_op(8'h12, 8'h34, 1'b0, 0);
    check("t1_state_exec", 32'(state_dbg), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("t1_done", 32'(done), 32'd1);
    check("t1_sum", 32'(sum_out), 32'h46);
    check("t1_busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t1_done_drop", 32'(done), 32'd0);

    // Carry chain: 0x00FF + 0x0001 = 0x0100, back-to-back
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 0);

    // Held strobe loads once
    @(negedge clk);
    data_in = 8'h77; chain = 1'b0; ld_strb = 1'b1;
    repeat (2) @(negedge clk);
    data_in = 8'h99;
    repeat (3) @(negedge clk);
    check("t3_state", 32'(state_dbg), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_op_a", 32'(add_a), 32'h77);
    ld_strb = 1'b0;
    exp_q.push_back(ref_add(32'h77, 32'h10, 1'b0));
    strobe(8'h10, 1'b0);

    // Strobe edge during S_EXEC (stretched with ena low), then clr
    do_op(8'hC0, 8'h50, 1'b0, 1);
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1; data_in = 8'h3C; ld_strb = 1'b1;
    @(negedge clk);
    ld_strb = 1'b0;
    check("t4_err", 32'(err), 32'd1);
    check("t4_state", 32'(state_dbg), 32'd0);
    check("t4_op_a_kept", 32'(add_a), 32'hC0);
    check("t4_sum", 32'({carry_out, sum_out}), 32'h110);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_carry = 0;
    check("t4_clr_err", 32'(err), 32'd0);
    check("t4_clr_sum", 32'(sum_out), 32'd0);
    check("t4_clr_carry", 32'(carry_out), 32'd0);
    check("t4_clr_op_a", 32'(add_a), 32'hC0);

    // ena low ignores strobes; re-enable with strobe high does not load
    ena = 1'b0;
    strobe(8'h55, 1'b0);
    check("t5_state", 32'(state_dbg), 32'd0);
    check("t5_op_a", 32'(add_a), 32'hC0);
    @(negedge clk);
    data_in = 8'h66; ld_strb = 1'b1;
    @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_reen_state", 32'(state_dbg), 32'd0);
    check("t5_reen_op_a", 32'(add_a), 32'hC0);
    ld_strb = 1'b0;
    do_op(8'h21, 8'h22, 1'b0, 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset while in S_B
    strobe(8'h99, 1'b0);
    check("t6_state_b", 32'(state_dbg), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_all", 32'({add_a, add_b, add_cin, sum_out, carry_out, busy, done, err, state_dbg}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_carry = 0;
    do_op(8'h05, 8'h03, 1'b0, 0);
    repeat (3) @(negedge clk);

    // Random chained operations
    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sumador_seq_ctrl.md
# sumador_seq_ctrl

Sequencing controller for the 8-bit adder datapath in the Tiny Tapeout top. It captures two operands from a shared 8-bit pin bus on successive load strobes and drives the external adder. It registers sum and carry, and supports chained multi-byte addition by feeding the stored carry back as carry-in. It sits between the `ui_in`/`uio_in` pins and the adder instance inside `tt_um_SUMADOR8BITS`.

## Interface
- `WIDTH`, 8, operand/sum width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  design selected; low freezes the FSM and ignores strobes.
- `data_in`  in  WIDTH  operand bus.
- `ld_strb`  in  1  load strobe; only the rising edge acts.
- `chain`  in  1  sampled with operand A; 1 = carry-in from stored carry, 0 = carry-in 0.
- `clr`  in  1  synchronous clear, highest priority after reset.
- `add_a`, `add_b`  out  WIDTH  operands to the adder: `op_a` and `op_b` registers.
- `add_cin`  out  1  carry-in to the adder: `cin_q` register.
- `add_sum`  in  WIDTH  adder sum (combinational from `add_*`).
- `add_cout`  in  1  adder carry-out.
- `sum_out`  out  WIDTH  registered result.
- `carry_out`  out  1  registered carry; also the chain source.
- `busy`  out  1  high when state ≠ S_A.
- `done`  out  1  one-cycle pulse when the result registers update.
- `err`  out  1  sticky; a strobe edge arrived while in S_EXEC.
- `state_dbg`  out  2  current state encoding.

## Operation
- Edge detect: `strb_q` <= `ld_strb` every cycle, regardless of `ena`. `rise` = `ld_strb` & ~`strb_q` & `ena`. A strobe held high loads exactly once.
- States: S_A=0 (wait operand A), S_B=1 (wait operand B), S_EXEC=2. Encoding 3 is unused and recovers to S_A on the next cycle.
- S_A, `rise`:
  - `op_a` <= `data_in`.
  - `cin_q` <= `chain` ? `carry_out` : 0.
  - Next state S_B.
- S_B, `rise`: `op_b` <= `data_in`; next state S_EXEC.
- S_EXEC (unconditional, one cycle):
  - `sum_out` <= `add_sum`, `carry_out` <= `add_cout`.
  - `done` <= 1 (registered, so it is high in the cycle after S_EXEC).
  - Next state S_A.
- Strobe edge in S_EXEC: the operand is dropped, `err` <= 1, and the state still goes to S_A.
- `clr`: state <= S_A, `sum_out`, `carry_out`, `cin_q` and `err` <= 0, `done` <= 0. `op_a` and `op_b` are kept. `clr` wins over a simultaneous `rise` and over S_EXEC.
- `ena`=0: state, operand and result registers hold, and `done` is forced to 0. `clr` still acts.
- Width rule: the sum is modulo 2^WIDTH, and overflow appears only in `carry_out`. A chain of N operations adds N·WIDTH-bit numbers LSB-byte first.
- Reset values:
  - state S_A.
  - All registers (`op_a`, `op_b`, `cin_q`, `sum_out`, `carry_out`, `strb_q`, `err`) are 0.
  - Therefore `done`=0, `busy`=0, `err`=0, `state_dbg`=0.
- Reset mid-operation aborts immediately. The state returns to S_A and a partially loaded operand is discarded.

## Timing
- `rise` is seen in the cycle where `ld_strb` is first sampled high. The operand register updates at the end of that cycle.
- The B-strobe edge at cycle n puts the FSM in S_EXEC at n+1.
- `sum_out`, `carry_out` and `done` are valid at n+2. `done` drops at n+3.
- `busy` is high from the cycle after the A load until the cycle S_EXEC ends.
- The minimum operation takes 2 strobe edges plus 1 execute cycle. Back-to-back operations are possible: the A strobe may rise in the same cycle `done` is high.
- The adder path `op` regs → `add_sum` → `sum_out` is single-cycle combinational with no multicycle allowance.

## Structure
- Package `sumador_pkg`:
  - `WIDTH_DEF` = 8.
  - State enum `seq_state_t` {S_A, S_B, S_EXEC}, 2 bits.
- Sub-module `strb_edge`: rising-edge detector with `clk`, `rst_n`, `d`, `en` and output `rise`.
- The adder itself is instantiated in the top, not inside this block.

## Test plan
- Reset, then load A=0x12 and B=0x34 with `chain`=0 → `sum_out`=0x46, `carry_out`=0, and a single `done` pulse 2 cycles after the B edge.
- A=0xFF, B=0x01, `chain`=0 → `sum_out`=0x00, `carry_out`=1. Then A=0x00 with `chain`=1 and B=0x00 → `sum_out`=0x01, `carry_out`=0 (16-bit result 0x0100).
- `ld_strb` held high for 5 cycles in S_A → only `op_a` loads; state is S_B and `busy`=1.
- Strobe edge during S_EXEC → `err`=1 and state S_A; a following `clr` → `err`=0, `sum_out`=0, `carry_out`=0.
- `ena`=0 with strobe edges → no state change. Re-enable while `ld_strb` is still high → no load until the next rising edge.
- Assert `rst_n`=0 while in S_B → all outputs are 0 immediately (asynchronously); after release, A=0x05 and B=0x03 gives `sum_out`=0x08.
